// File: rtl/ram_sdp_rd_arb_pkg.sv
// Shared types and constants for the SDP RAM read arbiter.
//   state_t    : controller state (init sweep / normal run)
//   tag_t      : {vld, id} entry of the read-latency tag pipe
//   STAT_CNT_W : width of each per-requester grant counter
// Package typedefs cannot depend on a module parameter, so the tag id is
// sized for the largest supported requester count (8). Smaller
// configurations zero-extend the grant index into it.
package ram_sdp_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int STAT_CNT_W = 16;
  localparam int MAX_REQ    = 8;
  localparam int TAG_ID_W   = $clog2(MAX_REQ);

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/ram_sdp_rd_arb_rr_arb.sv
// Round-robin arbiter, one grant per cycle.
//   clk, rst : clock and async active-high reset (priority pointer only)
//   req[N]   : request vector
//   en       : when low, no grant is issued and the pointer holds
//   gnt[N]   : one-hot grant (combinational)
//   gnt_idx  : index of the granted requester
// Search starts at last+1; the pointer resets to N-1 so requester 0 has
// first priority after reset.
module rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_q;

  // Scan from lowest to highest priority; the last hit overwrites earlier
  // ones, so the requester nearest to last+1 wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (en) begin
      for (int k = N; k >= 1; k--) begin
        if (req[IDX_W'((int'(last_q) + k) % N)]) begin
          gnt                                 = '0;
          gnt[IDX_W'((int'(last_q) + k) % N)] = 1'b1;
          gnt_idx                             = IDX_W'((int'(last_q) + k) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(N - 1);
    end else if (|gnt) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/ram_sdp_rd_arb.sv
// Owner of an external simple-dual-port RAM (2-cycle read latency).
// Sweeps the RAM with INIT_VALUE after reset / init_req, then passes one
// writer through to the write port and shares the read port round-robin
// among NUM_REQ requesters, routing each response back to its issuer.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   init_req / init_done     : restart init sweep / high in RUN
//   rd_req_valid/ready/addr  : per-requester read request, one-hot grant
//   rd_rsp_valid/data        : one-hot response strobe, shared data
//   wr_valid/ready/addr/data : single write client
//   ram_wr_*, ram_rd_*       : RAM ports
//   stat_grant_cnt           : per-requester saturating grant counters
// Optional: define RAM_SDP_RD_ARB_STAT_EN to build the grant counters;
// otherwise stat_grant_cnt is tied to 0.
//
// state   | meaning
// ST_INIT | write INIT_VALUE to address cnt, one word per cycle; no grants
// ST_RUN  | write passthrough and read arbitration active
module ram_sdp_rd_arb
  import ram_sdp_arb_pkg::*;
#(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 32,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               init_req,
  output logic                               init_done,
  input  logic [NUM_REQ-1:0]                 rd_req_valid,
  output logic [NUM_REQ-1:0]                 rd_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      rd_req_addr,
  output logic [NUM_REQ-1:0]                 rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]              rd_rsp_data,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               ram_wr_en,
  output logic [ADDR_WIDTH-1:0]              ram_wr_addr,
  output logic [DATA_WIDTH-1:0]              ram_wr_data,
  output logic                               ram_rd_en,
  output logic [ADDR_WIDTH-1:0]              ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]              ram_rd_data,
  output logic [NUM_REQ*STAT_CNT_W-1:0]      stat_grant_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  arb_en;
  tag_t                  tag_q [2];
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = rd_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held at their reset values while rst is high, so the
  // sweep does not start writing before reset is released.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done   = 1'b0;
    wr_ready    = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          ram_wr_en   = 1'b1;
          ram_wr_addr = cnt_q;
          ram_wr_data = INIT_VALUE;
          if (init_req) begin
            cnt_d = '0;
          end else if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          init_done   = 1'b1;
          wr_ready    = 1'b1;
          ram_wr_en   = wr_valid;
          ram_wr_addr = wr_addr;
          ram_wr_data = wr_data;
          if (init_req) begin
            state_d = ST_INIT;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // No grant in the cycle that leaves RUN.
  assign arb_en = (state_q == ST_RUN) && !init_req && !rst;

  rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign rd_req_ready = gnt;
  assign ram_rd_en    = |gnt;
  assign ram_rd_addr  = (|gnt) ? addr_arr[gnt_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      rsp_data_q <= '0;
    end else begin
      tag_q[0]   <= '{vld: |gnt, id: TAG_ID_W'(gnt_idx)};
      tag_q[1]   <= tag_q[0];
      rsp_data_q <= rd_rsp_data;
    end
  end

  // RAM data is only valid in the tag's final stage; hold the last word
  // otherwise.
  assign rd_rsp_valid = tag_q[1].vld ? (NUM_REQ'(1) << tag_q[1].id) : '0;
  assign rd_rsp_data  = tag_q[1].vld ? ram_rd_data : rsp_data_q;

`ifdef RAM_SDP_RD_ARB_STAT_EN
  logic [STAT_CNT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (state_d == ST_INIT) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_grant_cnt[gi*STAT_CNT_W +: STAT_CNT_W] = stat_q[gi];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_sdp_rd_arb.sv
module tb_ram_sdp_rd_arb;
  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam logic [DW-1:0] INIT_V = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    init_req, init_done;
  logic [NUM_REQ-1:0]      rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [NUM_REQ*AW-1:0]   rd_req_addr;
  logic [DW-1:0]           rd_rsp_data;
  logic                    wr_valid, wr_ready;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           wr_data;
  logic                    ram_wr_en, ram_rd_en;
  logic [AW-1:0]           ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]           ram_wr_data, ram_rd_data;
  logic [NUM_REQ*16-1:0]   stat_grant_cnt;

  ram_sdp_rd_arb #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .stat_grant_cnt(stat_grant_cnt)
  );

  // External RAM: inputs registered (read samples the array before a
  // same-edge write lands), output registered.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_0000 | DW'(i);
    end else if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
    end
    if (ram_rd_en) rd_s1 <= mem[ram_rd_addr];
    ram_rd_data <= rd_s1;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit            m_run;
  int            m_cnt, m_last, m_g;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            p_vld [2];
  int            p_id  [2];
  logic [DW-1:0] p_data [2];
  logic [DW-1:0] m_hold;
  int            m_stat [NUM_REQ];
  int            dut_gcnt [NUM_REQ];
  int            rsp_seen;
  logic [NUM_REQ-1:0] obs_ready, obs_rsp_valid;
  logic [DW-1:0]      obs_rsp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_last = NUM_REQ - 1; m_g = -1; m_hold = '0;
    p_vld[0] = 0; p_vld[1] = 0;
    for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
  endtask

  // One clock cycle: compare DUT against the model at the negedge, then
  // advance the model and return #1 after the next posedge.
  task automatic step();
    int g;
    logic [NUM_REQ-1:0] eg, erv;
    logic [DW-1:0] ed;
    @(negedge clk);
    g  = (m_run && !init_req) ? rr_pick(rd_req_valid, m_last) : -1;
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("init_done", init_done, m_run);
    chk("wr_ready", wr_ready, m_run);
    if (m_run) begin
      chk("ram_wr_en", ram_wr_en, wr_valid);
      if (wr_valid) begin
        chk("ram_wr_addr", ram_wr_addr, wr_addr);
        chk("ram_wr_data", ram_wr_data, wr_data);
      end
    end else begin
      chk("init_wr_en", ram_wr_en, 1);
      chk("init_wr_addr", ram_wr_addr, m_cnt);
      chk("init_wr_data", ram_wr_data, INIT_V);
    end
    chk("rd_req_ready", rd_req_ready, eg);
    chk("ram_rd_en", ram_rd_en, g >= 0);
    if (g >= 0) chk("ram_rd_addr", ram_rd_addr, rd_req_addr[g*AW +: AW]);
    erv = '0;
    if (p_vld[1]) erv[p_id[1]] = 1'b1;
    ed = p_vld[1] ? p_data[1] : m_hold;
    chk("rd_rsp_valid", rd_rsp_valid, erv);
    chk("rd_rsp_data", rd_rsp_data, ed);
    m_hold = ed;
`ifdef RAM_SDP_RD_ARB_STAT_EN
    for (int i = 0; i < NUM_REQ; i++) chk("stat_cnt", stat_grant_cnt[i*16 +: 16], m_stat[i]);
`else
    chk("stat_zero", stat_grant_cnt, 0);
`endif
    obs_ready = rd_req_ready; obs_rsp_valid = rd_rsp_valid; obs_rsp_data = rd_rsp_data;
    if (|rd_rsp_valid) rsp_seen++;
    for (int i = 0; i < NUM_REQ; i++) dut_gcnt[i] += int'(rd_req_ready[i]);
    // advance model
    p_vld[1] = p_vld[0]; p_id[1] = p_id[0]; p_data[1] = p_data[0];
    p_vld[0] = (g >= 0);
    p_id[0]  = (g >= 0) ? g : 0;
    p_data[0] = (g >= 0) ? ref_mem[rd_req_addr[g*AW +: AW]] : '0;
    if (g >= 0) begin
      m_last = g;
      if (m_stat[g] < 65535) m_stat[g]++;
    end
    if (m_run) begin
      if (wr_valid) ref_mem[wr_addr] = wr_data;
      if (init_req) begin
        m_run = 0; m_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
      end
    end else begin
      ref_mem[m_cnt] = INIT_V;
      if (init_req) m_cnt = 0;
      else if (m_cnt == DEPTH - 1) begin m_run = 1; m_cnt = 0; end
      else m_cnt++;
    end
    m_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd_req_ready", rd_req_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_ram_wr_en", ram_wr_en, 0);
      chk("rst_ram_rd_en", ram_rd_en, 0);
      chk("rst_rd_rsp_valid", rd_rsp_valid, 0);
      chk("rst_rd_rsp_data", rd_rsp_data, 0);
      chk("rst_ram_wr_addr", ram_wr_addr, 0);
      chk("rst_ram_wr_data", ram_wr_data, 0);
      chk("rst_ram_rd_addr", ram_rd_addr, 0);
      chk("rst_stat", stat_grant_cnt, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    init_req = 0; rd_req_valid = '0; rd_req_addr = '0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; rsp_seen = 0;
    for (int i = 0; i < NUM_REQ; i++) dut_gcnt[i] = 0;
    do_reset();

    // Init sweep with requests and writes pending: nothing may be accepted.
    rd_req_valid = '1; wr_valid = 1; wr_addr = 5; wr_data = 32'hBAD0_BAD0;
    for (int i = 0; i < NUM_REQ; i++) rd_req_addr[i*AW +: AW] = AW'(i);
    for (int c = 0; c < DEPTH; c++) step();
    chk("init_done_after_sweep", init_done, 1);
    for (int i = 0; i < DEPTH; i++) chk("init_mem", mem[i], INIT_V);
    rd_req_valid = '0; wr_valid = 0;

    // Write addr 3, read it back via requester 1 the next cycle.
    wr_valid = 1; wr_addr = 3; wr_data = 32'hA5A5_0003; step();
    wr_valid = 0; rd_req_valid = 4'b0010; rd_req_addr[1*AW +: AW] = 3; step();
    rd_req_valid = '0; step(); step();
    chk("wr_then_rd_valid", obs_rsp_valid, 4'b0010);
    chk("wr_then_rd_data", obs_rsp_data, 32'hA5A5_0003);

    // Same-cycle write/read of addr 7 returns old data; next read sees new.
    wr_valid = 1; wr_addr = 7; wr_data = 32'h7777_0007;
    rd_req_valid = 4'b0001; rd_req_addr[0*AW +: AW] = 7; step();
    wr_valid = 0; step();
    rd_req_valid = '0; step();
    chk("same_cycle_valid", obs_rsp_valid, 4'b0001);
    chk("same_cycle_old_data", obs_rsp_data, 32'h0);
    step();
    chk("next_cycle_new_data", obs_rsp_data, 32'h7777_0007);

    // Move the pointer to 3 so the fairness run starts at requester 0.
    rd_req_valid = 4'b1000; step();
    for (int i = 0; i < NUM_REQ; i++) begin
      dut_gcnt[i] = 0;
      rd_req_addr[i*AW +: AW] = AW'(10 + i);
    end
    rd_req_valid = '1;
    repeat (12) step();
    rd_req_valid = '0; step(); step();
    for (int i = 0; i < NUM_REQ; i++) chk("rr_fair_cnt", dut_gcnt[i], 3);

    // init_req with two reads in flight: both responses still delivered.
    rsp_seen = 0;
    rd_req_valid = 4'b0011; rd_req_addr[0*AW +: AW] = 3; rd_req_addr[1*AW +: AW] = 7; step();
    rd_req_valid = 4'b0010; step();
    rd_req_valid = '1; wr_valid = 1; init_req = 1; step();
    init_req = 0;
    repeat (DEPTH) step();
    chk("init_req_rsp_count", rsp_seen, 2);
    chk("init_req_done_again", init_done, 1);
    rd_req_valid = '0; wr_valid = 0;

    // Randomized traffic on a small address window.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_g == i || !rd_req_valid[i]) begin
          rd_req_valid[i] = ($urandom_range(0, 99) < 60);
          rd_req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        end else if ($urandom_range(0, 9) == 0) begin
          rd_req_valid[i] = 1'b0;
        end
      end
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      init_req = ($urandom_range(0, 149) == 0);
      step();
    end
    init_req = 0; wr_valid = 0; rd_req_valid = '0;
    for (int k = 0; k < DEPTH + 2 && !m_run; k++) step();
    chk("run_before_mid_reset", init_done, 1);

    // Reset with a read in flight drops its response.
    rd_req_valid = 4'b0100; rd_req_addr[2*AW +: AW] = 3; step();
    rd_req_valid = '0;
    do_reset();
    for (int c = 0; c < DEPTH; c++) step();
    rd_req_valid = '1; step();
    chk("post_reset_first_prio", obs_ready, 4'b0001);
    rd_req_valid = '0; step(); step();

`ifdef RAM_SDP_RD_ARB_STAT_EN
    rd_req_valid = 4'b0100;
    repeat (70000) step();
    rd_req_valid = '0; step();
    chk("stat_saturated", stat_grant_cnt[2*16 +: 16], 16'hFFFF);
    init_req = 1; step();
    init_req = 0; step();
    chk("stat_cleared", stat_grant_cnt[2*16 +: 16], 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
